rv_skid_buffer: RTL

- Two-entry ready/valid register slice that registers the backward (ready) path as well as the forward (valid/data) path.
- It complements the team's forward-only pipeline register, in which in_ready is combinational from out_ready. This block breaks the long combinational ready chain from sink back to source.
- Inserted between any producer and consumer on the 16-bit streaming interfaces; it can be chained with the forward register.
- Also provides occupancy, flush and a saturating stall counter for debug.

---
 rtl/rv_pkg.sv | 18 +
 rtl/rv_sat_counter.sv | 33 +++
 rtl/rv_skid_buffer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the ready/valid streaming blocks.
//
// Contents:
//   RV_DATA_W        default payload width of the 16-bit streaming interfaces
//                    (shared with the forward-only pipeline register)
//   rv_skid_state_t  skid buffer state; the encoding equals the number of
//                    held entries, so the state register doubles as occupancy
package rv_pkg;

  localparam int RV_DATA_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing held
    BUSY  = 2'd1,  // main register valid
    FULL  = 2'd2   // main and skid registers valid
  } rv_skid_state_t;

endpackage

// File: rtl/rv_sat_counter.sv
// Saturating up-counter, reusable by any stream block that wants a debug
// event count that sticks at its maximum instead of wrapping.
//
// Ports:
//   clk   rising-edge clock
//   clr   synchronous clear (highest priority)
//   inc   count one event this cycle
//   cnt   current count, holds at 2^CNT_W-1 once reached
module rv_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rv_skid_buffer.sv
// Two-entry ready/valid register slice. Both the forward path (out_valid,
// data_out) and the backward path (in_ready) come straight from flops, so
// the combinational ready chain from sink to source is cut here.
//
// Handshake: a word moves when valid and ready are both high on a rising
// edge (accept = in_valid & in_ready, pop = out_valid & out_ready). The
// producer holds data_in/in_valid until accept; this block holds
// data_out/out_valid until pop. data_out is meaningless while out_valid=0.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   flush           synchronous drop of all held data (stall_cnt kept)
//   data_in         upstream payload
//   in_valid        upstream valid
//   in_ready        upstream ready (flop, independent of out_ready)
//   data_out        downstream payload (main register)
//   out_valid       downstream valid (flop)
//   out_ready       downstream ready
//   occupancy       held entries 0..2 (same as the FSM state encoding)
//   stall_cnt       saturating count of cycles with out_valid & !out_ready
module rv_skid_buffer
  import rv_pkg::*;
#(
  parameter int DATA_W = RV_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  rv_skid_state_t state_q;
  rv_skid_state_t state_d;    // next state from the handshake alone
  rv_skid_state_t state_nxt;  // next state after flush override

  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  logic accept;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  // Next-state and payload-steering decode.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = BUSY;
          load_main_in = 1'b1;
        end
      end
      BUSY: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          // Downstream stalled: the in-flight word lands in the skid slot.
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          state_d        = BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    state_nxt = flush ? EMPTY : state_d;
  end

  // Control flops. in_ready/out_valid are precomputed from the next state
  // so the ports are driven by flops rather than a decode of state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  // Payload registers carry no reset; their contents only matter while the
  // state says they are valid, so loads during flush/reset are harmless.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_q <= data_in;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= data_in;
    end
  end

  rv_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (out_valid_q & ~out_ready),
    .cnt (stall_cnt)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = main_q;
  assign occupancy = state_q;

endmodule
